// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared constants, state type and lane helpers for the LPC Levinson sequencer
//
// Contents:
//   LPC_ORDER, N_LANES : recursion order and coefficient lane count (order + 1)
//   COEF_W, ACC_W      : coefficient width (Q15) and widened lane width toward coeff_update
//   Q15_ONE            : a[0] value, fixed for the whole frame
//   lpc_state_t        : sequencer FSM states
//   coef_lane()        : extract one COEF_W lane from a packed coefficient vector
//   sext_coef()        : sign-extend one coefficient to ACC_W
package lpc_pkg;

    localparam int LPC_ORDER = 10;
    localparam int N_LANES   = LPC_ORDER + 1;
    localparam int COEF_W    = 16;
    localparam int ACC_W     = 32;

    localparam logic [COEF_W-1:0] Q15_ONE = 16'h7FFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ_K    = 3'd1,
        ISSUE    = 3'd2,
        WAIT_UPD = 3'd3,
        WB       = 3'd4,
        DONE     = 3'd5
    } lpc_state_t;

    function automatic logic [COEF_W-1:0] coef_lane(
        input logic [N_LANES*COEF_W-1:0] vec,
        input int                        lane
    );
        return vec[lane*COEF_W +: COEF_W];
    endfunction

    function automatic logic [ACC_W-1:0] sext_coef(input logic [COEF_W-1:0] c);
        return {{(ACC_W-COEF_W){c[COEF_W-1]}}, c};
    endfunction

endpackage

// File: rtl/levinson_lane_mux.sv
// rtl/levinson_lane_mux.sv - builds forward/reversed coefficient vectors for one recursion step
//
// Combinational. For order i:
//   o_al lane j = sext(a[j])   for j <= i, else 0
//   o_ar lane j = sext(a[i-j]) for j <= i, else 0
// Ports:
//   i_coef : packed a[0..LPC_ORDER], COEF_W per lane
//   i_idx  : current order i (1..LPC_ORDER)
//   o_al   : forward vector, ACC_W per lane
//   o_ar   : reversed vector, ACC_W per lane
module levinson_lane_mux
    import lpc_pkg::*;
(
    input  logic [N_LANES*COEF_W-1:0] i_coef,
    input  logic [3:0]                i_idx,
    output logic [N_LANES*ACC_W-1:0]  o_al,
    output logic [N_LANES*ACC_W-1:0]  o_ar
);

    always_comb begin
        o_al = '0;
        o_ar = '0;
        for (int j = 0; j < N_LANES; j++) begin
            // The idx range guard keeps the reversed index inside a[] even if
            // an illegal order value ever reaches this block.
            if ((j <= int'(i_idx)) && (int'(i_idx) <= LPC_ORDER)) begin
                o_al[j*ACC_W +: ACC_W] = sext_coef(coef_lane(i_coef, j));
                o_ar[j*ACC_W +: ACC_W] = sext_coef(coef_lane(i_coef, int'(i_idx) - j));
            end
        end
    end

endmodule

// File: rtl/levinson_sequencer.sv
// rtl/levinson_sequencer.sv - Levinson-Durbin recursion sequencer owning the LPC coefficient file
//
// Optional feature: define LPC_SEQ_WDOG_EN to enable the wait watchdog and sticky err.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a frame (ignored unless idle)
//   busy, done        : frame in progress / one-cycle completion pulse
//   k_req, k_idx      : request reflection coefficient k_i, current order i
//   k_valid, k_in     : reflection coefficient handshake and Q15 value
//   upd_v             : one-cycle issue strobe to coeff_update
//   upd_k, upd_aL/aR  : held k_i and forward/reversed coefficient vectors
//   upd_a_next        : coeff_update results, upd_vout their valid level
//   coef_out          : current a[] register file
//   err               : sticky watchdog error (0 without LPC_SEQ_WDOG_EN)
module levinson_sequencer
    import lpc_pkg::*;
#(
    parameter int ORDER       = 10,
    parameter int UPD_LAT     = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      k_req,
    output logic [3:0]                k_idx,
    input  logic                      k_valid,
    input  logic [15:0]               k_in,
    output logic                      upd_v,
    output logic [15:0]               upd_k,
    output logic [(ORDER+1)*32-1:0]   upd_aL,
    output logic [(ORDER+1)*32-1:0]   upd_aR,
    input  logic [(ORDER+1)*16-1:0]   upd_a_next,
    input  logic                      upd_vout,
    output logic [(ORDER+1)*16-1:0]   coef_out,
    output logic                      err
);

    // One width serves both the latency counter and the watchdog counter.
    localparam int CNT_W = $clog2(((UPD_LAT > WDOG_CYCLES) ? UPD_LAT : WDOG_CYCLES) + 1);

    localparam logic [N_LANES*COEF_W-1:0] A_RESET =
        {{((N_LANES-1)*COEF_W){1'b0}}, Q15_ONE};

    lpc_state_t                      r_state;
    lpc_state_t                      w_next;
    logic [3:0]                      r_i;
    logic [COEF_W-1:0]               r_k;
    logic [CNT_W-1:0]                r_cnt;
    logic [N_LANES*COEF_W-1:0]       r_a;
    logic [N_LANES*ACC_W-1:0]        r_al;
    logic [N_LANES*ACC_W-1:0]        r_ar;
    logic [(N_LANES-1)*COEF_W-1:0]   r_anext;
    logic [N_LANES*ACC_W-1:0]        w_al;
    logic [N_LANES*ACC_W-1:0]        w_ar;
    logic                            w_lat_ok;
    logic                            w_wd_trip;
    logic                            w_unused_lane0;

    // a[0] is fixed at Q15 one, so the lane 0 result is never written back.
    assign w_unused_lane0 = ^upd_a_next[COEF_W-1:0];

    // r_cnt is 0 in the first WAIT_UPD cycle, so the UPD_LAT-th wait cycle
    // is the first one allowed to sample; earlier upd_vout may be stale.
    assign w_lat_ok = (r_cnt >= CNT_W'(UPD_LAT - 1));

    levinson_lane_mux u_lane_mux (
        .i_coef (r_a),
        .i_idx  (r_i),
        .o_al   (w_al),
        .o_ar   (w_ar)
    );

`ifdef LPC_SEQ_WDOG_EN
    logic [CNT_W-1:0] r_wd;
    logic             r_err;
    logic             w_in_wait;

    assign w_in_wait = (r_state == REQ_K) || (r_state == WAIT_UPD);
    assign w_wd_trip = w_in_wait && (r_wd == CNT_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_wd <= w_in_wait ? r_wd + 1'b1 : '0;
            if ((r_state == IDLE) && start) begin
                r_err <= 1'b0;
            end else if (w_wd_trip && (w_next == DONE)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_wd_trip = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        k_req  = 1'b0;
        upd_v  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = REQ_K;
                end
            end
            REQ_K: begin
                busy  = 1'b1;
                k_req = 1'b1;
                if (k_valid) begin
                    w_next = ISSUE;
                end else if (w_wd_trip) begin
                    w_next = DONE;
                end
            end
            ISSUE: begin
                busy   = 1'b1;
                upd_v  = 1'b1;
                w_next = WAIT_UPD;
            end
            WAIT_UPD: begin
                busy = 1'b1;
                if (w_lat_ok && upd_vout) begin
                    w_next = WB;
                end else if (w_wd_trip) begin
                    w_next = DONE;
                end
            end
            WB: begin
                busy   = 1'b1;
                w_next = (r_i == 4'(ORDER)) ? DONE : REQ_K;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i     <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
            r_a     <= A_RESET;
            r_al    <= '0;
            r_ar    <= '0;
            r_anext <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_i <= 4'd1;
                        r_a <= A_RESET;
                    end
                end
                REQ_K: begin
                    // a[] and i are stable here, so the issue vectors are
                    // latched together with k and held until the next step.
                    if (k_valid) begin
                        r_k  <= k_in;
                        r_al <= w_al;
                        r_ar <= w_ar;
                    end
                end
                ISSUE: begin
                    r_cnt <= '0;
                end
                WAIT_UPD: begin
                    if (!w_lat_ok) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_lat_ok && upd_vout) begin
                        r_anext <= upd_a_next[N_LANES*COEF_W-1:COEF_W];
                    end
                end
                WB: begin
                    for (int j = 1; j < N_LANES; j++) begin
                        if (j <= int'(r_i)) begin
                            r_a[j*COEF_W +: COEF_W] <= r_anext[(j-1)*COEF_W +: COEF_W];
                        end
                    end
                    if (r_i != 4'(ORDER)) begin
                        r_i <= r_i + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign k_idx    = r_i;
    assign upd_k    = r_k;
    assign upd_aL   = r_al;
    assign upd_aR   = r_ar;
    assign coef_out = r_a;

endmodule

// File: tb/tb_levinson_sequencer.sv
// tb/tb_levinson_sequencer.sv - randomized self-checking bench for levinson_sequencer
module tb_levinson_sequencer;
    import lpc_pkg::*;

    localparam int ORDER = 10;
    localparam int NL    = ORDER + 1;
    localparam logic [175:0] A_INIT = {160'h0, 16'h7FFF};

    logic         clk;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic         k_req;
    logic [3:0]   k_idx;
    logic         k_valid;
    logic [15:0]  k_in;
    logic         upd_v;
    logic [15:0]  upd_k;
    logic [351:0] upd_aL;
    logic [351:0] upd_aR;
    logic [175:0] upd_a_next;
    logic         upd_vout;
    logic [175:0] coef_out;
    logic         err;

    levinson_sequencer #(.ORDER(10), .UPD_LAT(4), .WDOG_CYCLES(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .k_req      (k_req),
        .k_idx      (k_idx),
        .k_valid    (k_valid),
        .k_in       (k_in),
        .upd_v      (upd_v),
        .upd_k      (upd_k),
        .upd_aL     (upd_aL),
        .upd_aR     (upd_aR),
        .upd_a_next (upd_a_next),
        .upd_vout   (upd_vout),
        .coef_out   (coef_out),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [351:0] act, input logic [351:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the coefficient recursion itself, step by step.
    logic [15:0] m_a [NL];
    logic [15:0] m_k [NL];
    int          m_i;
    bit          m_active;
    bit          m_err;
    bit          chk_en;
    bit          wdog_phase;
    bit          hold_mode;
    int          kv_mode;
    int          upd_cnt;
    logic [31:0] snap_al1;

    function automatic void model_init();
        m_a[0] = 16'h7FFF;
        for (int j = 1; j < NL; j++) m_a[j] = 16'h0;
        m_i = 0;
    endfunction

    function automatic logic [175:0] model_vec();
        logic [175:0] v;
        for (int j = 0; j < NL; j++) v[j*16 +: 16] = m_a[j];
        return v;
    endfunction

    // coeff_update stand-in: a_next = aL + ((aR*k) >>> 15), four-cycle latency.
    function automatic logic [175:0] stub_calc(input logic [351:0] al, input logic [351:0] ar,
                                               input logic [15:0] k);
        logic [175:0] r;
        longint       s;
        for (int j = 0; j < NL; j++) begin
            s = longint'($signed(al[j*32 +: 32])) +
                ((longint'($signed(ar[j*32 +: 32])) * longint'($signed(k))) >>> 15);
            r[j*16 +: 16] = s[15:0];
        end
        return r;
    endfunction

    logic         pv [3];
    logic [175:0] pd [3];

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                pv[s] <= 1'b0;
                pd[s] <= '0;
            end
            upd_vout   <= 1'b0;
            upd_a_next <= '0;
        end else begin
            pv[0] <= upd_v;
            pd[0] <= stub_calc(upd_aL, upd_aR, upd_k);
            for (int s = 1; s < 3; s++) begin
                pv[s] <= pv[s-1];
                pd[s] <= pd[s-1];
            end
            if (pv[2]) begin
                upd_vout   <= 1'b1;
                upd_a_next <= pd[2];
            end else if (!hold_mode) begin
                upd_vout <= 1'b0;
            end
        end
    end

    // Reflection-coefficient source: offers k for the model's next order.
    always @(posedge clk) begin
        #3;
        case (kv_mode)
            0:       k_valid = 1'b1;
            1:       k_valid = 1'($urandom_range(0, 1));
            default: k_valid = 1'b0;
        endcase
        k_in = (m_i < ORDER) ? m_k[m_i+1] : 16'h0;
    end

    // Compare process.
    always @(negedge clk) begin
        logic [351:0] eal;
        logic [351:0] ear;
        logic [15:0]  na [NL];
        longint       s;
        if (!rst && chk_en) begin
            if (upd_v) begin
                m_i++;
                upd_cnt++;
                chk("k_idx", {348'h0, k_idx}, m_i);
                if (m_i <= ORDER) begin
                    eal = '0;
                    ear = '0;
                    for (int j = 0; j <= m_i; j++) begin
                        eal[j*32 +: 32] = {{16{m_a[j][15]}}, m_a[j]};
                        ear[j*32 +: 32] = {{16{m_a[m_i-j][15]}}, m_a[m_i-j]};
                    end
                    chk("upd_k", {336'h0, upd_k}, {336'h0, m_k[m_i]});
                    chk("upd_aL", upd_aL, eal);
                    chk("upd_aR", upd_aR, ear);
                    if (m_i == 2) snap_al1 = upd_aL[32 +: 32];
                    for (int j = 0; j < NL; j++) na[j] = m_a[j];
                    for (int j = 1; j <= m_i; j++) begin
                        s = longint'($signed(m_a[j])) +
                            ((longint'($signed(m_a[m_i-j])) * longint'($signed(m_k[m_i]))) >>> 15);
                        na[j] = s[15:0];
                    end
                    for (int j = 0; j < NL; j++) m_a[j] = na[j];
                end
            end
            if (done) begin
                if (wdog_phase) m_err = 1'b1;
                chk("busy_at_done", {351'h0, busy}, 0);
                chk("coef_at_done", {176'h0, coef_out}, {176'h0, model_vec()});
                if (!wdog_phase) chk("steps_at_done", m_i, ORDER);
                m_active = 1'b0;
            end else begin
                chk("busy", {351'h0, busy}, {351'h0, m_active});
            end
            chk("err", {351'h0, err}, {351'h0, m_err});
        end
    end

    task automatic accept_start();
        if (!m_active) begin
            m_active = 1'b1;
            m_err    = 1'b0;
            model_init();
        end
    endtask

    task automatic rand_k();
        for (int j = 1; j < NL; j++) m_k[j] = 16'(int'($urandom_range(0, 16'h6000)) - 16'h3000);
    endtask

    // Cycles are numbered with the start cycle as 1; cyc ends as the done cycle.
    task automatic run_frame(input int kvm, input bit hold, input bit glitch, output int cyc);
        int n0;
        kv_mode   = kvm;
        hold_mode = hold;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        accept_start();
        n0  = upd_cnt;
        cyc = 2;
        while (!done && cyc < 2000) begin
            start = glitch && (cyc == 10 || cyc == 40);
            @(posedge clk);
            #2;
            cyc++;
        end
        start = 1'b0;
        chk("frame_done_seen", {351'h0, done}, 1);
        if (!wdog_phase) chk("upd_v_count", upd_cnt - n0, ORDER);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int cyc;
        int n;
        rst = 1'b1; start = 1'b0; k_valid = 1'b0; k_in = '0;
        kv_mode = 0; hold_mode = 1'b0; chk_en = 1'b0; wdog_phase = 1'b0;
        m_active = 1'b0; m_err = 1'b0; upd_cnt = 0; snap_al1 = '0;
        model_init();
        for (int j = 0; j < NL; j++) m_k[j] = 16'h0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", {351'h0, busy}, 0);
        chk("rst_done", {351'h0, done}, 0);
        chk("rst_k_req", {351'h0, k_req}, 0);
        chk("rst_upd_v", {351'h0, upd_v}, 0);
        chk("rst_k_idx", {348'h0, k_idx}, 0);
        chk("rst_err", {351'h0, err}, 0);
        chk("rst_coef", {176'h0, coef_out}, {176'h0, A_INIT});
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #2;

        // Hand-computed frame: k1=0x4000, k2=0x2000, rest zero.
        m_k[1] = 16'h4000;
        m_k[2] = 16'h2000;
        run_frame(0, 1'b0, 1'b0, cyc);
        chk("lit_cycles", cyc, 72);
        chk("lit_step1_a1", {320'h0, snap_al1}, 32'h0000_3FFF);
        chk("lit_a1", {336'h0, coef_out[16 +: 16]}, 16'h4FFE);
        chk("lit_a2", {336'h0, coef_out[32 +: 16]}, 16'h1FFF);
        chk("lit_a3_up", {208'h0, coef_out[175:48]}, 0);
        chk("lit_model_a1", {336'h0, m_a[1]}, 16'h4FFE);
        chk("lit_model_a2", {336'h0, m_a[2]}, 16'h1FFF);

        // All-zero reflection coefficients with k_valid held high.
        for (int j = 1; j < NL; j++) m_k[j] = 16'h0;
        n = upd_cnt;
        run_frame(0, 1'b0, 1'b0, cyc);
        chk("zero_cycles", cyc, 72);
        chk("zero_coef", {176'h0, coef_out}, {176'h0, A_INIT});
        chk("zero_upd_count", upd_cnt - n, 10);

        // upd_vout held high: stale results must not be captured early.
        rand_k();
        run_frame(0, 1'b1, 1'b0, cyc);
        chk("hold_cycles", cyc, 72);
        rand_k();
        run_frame(1, 1'b1, 1'b1, cyc);

        // Randomized frames, with start pulses while busy in some of them.
        for (int f = 0; f < 6; f++) begin
            rand_k();
            run_frame(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), cyc);
        end

        // Reset while waiting for the step-5 update.
        rand_k();
        kv_mode = 1; hold_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        accept_start();
        n = 0;
        while (m_i < 5 && n < 1000) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("rst_wait_reached", m_i, 5);
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        m_active = 1'b0;
        model_init();
        chk("abort_busy", {351'h0, busy}, 0);
        chk("abort_done", {351'h0, done}, 0);
        chk("abort_k_idx", {348'h0, k_idx}, 0);
        chk("abort_coef", {176'h0, coef_out}, {176'h0, A_INIT});
        rand_k();
        run_frame(0, 1'b0, 1'b0, cyc);
        chk("after_abort_cycles", cyc, 72);

`ifdef LPC_SEQ_WDOG_EN
        // k never arrives: 64 REQ_K cycles, then DONE.
        wdog_phase = 1'b1;
        run_frame(2, 1'b0, 1'b0, cyc);
        wdog_phase = 1'b0;
        chk("wdog_cycles", cyc, 66);
        chk("wdog_err", {351'h0, err}, 1);
        chk("wdog_coef", {176'h0, coef_out}, {176'h0, A_INIT});
        rand_k();
        run_frame(0, 1'b0, 1'b0, cyc);
        chk("wdog_clear_err", {351'h0, err}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/levinson_sequencer.md
Name: levinson_sequencer

Overview:
- Drives the Levinson-Durbin recursion for one LPC frame.
- Owns the predictor coefficient register file a[0..ORDER].
- For each order i = 1..ORDER:
  - requests reflection coefficient k_i from the reflection unit;
  - builds the forward and reversed coefficient vectors and issues one update to the coeff_update pipeline;
  - captures a_next and writes it back.
- Sits between the reflection-coefficient unit and coeff_update; reports the final coefficient set to the synthesis filter.

Parameters:
- ORDER, 10, LPC order (number of recursion steps). coeff_update is fixed at 11 lanes, so ORDER must be 10.
- UPD_LAT, 4, cycles from upd_v to valid upd_a_next.
- WDOG_CYCLES, 64, watchdog limit (only used with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin recursion (pulse; ignored unless IDLE)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when a[] is final
- k_req  out  1  level request for k_i
- k_idx  out  4  current order i (1..ORDER)
- k_valid  in  1  k_in valid (handshake k_req && k_valid)
- k_in  in  16  signed Q15 reflection coefficient
- upd_v  out  1  one-cycle issue strobe to coeff_update
- upd_k  out  16  signed, held k_i
- upd_aL  out  (ORDER+1)*32  lane j = sign-extended a[j] when j<=i, else 0
- upd_aR  out  (ORDER+1)*32  lane j = sign-extended a[i-j] when j<=i, else 0
- upd_a_next  in  (ORDER+1)*16  signed results from coeff_update
- upd_vout  in  1  result valid (treated as level)
- coef_out  out  (ORDER+1)*16  current a[] register file
- err  out  1  sticky error (optional feature only; tied 0 otherwise)

Behaviour:
- Reset:
  - a[0] = 16'h7FFF; a[1..ORDER] = 0.
  - busy, done, k_req, upd_v and err all 0; k_idx = 0; state IDLE.
  - Reset in any state aborts immediately; no writeback occurs.
- FSM states: IDLE, REQ_K, ISSUE, WAIT_UPD, WB, DONE.
  - IDLE: start=1 -> i=1, clear a[1..ORDER] to 0, busy=1 -> REQ_K.
  - REQ_K: k_req=1. On k_valid=1, capture k_in into the k register -> ISSUE. k_valid while not in REQ_K is ignored.
  - ISSUE: upd_v=1 for exactly one cycle; clear latency counter -> WAIT_UPD.
  - WAIT_UPD:
    - Counter increments each cycle.
    - Sample when counter >= UPD_LAT and upd_vout=1 -> WB.
    - Before UPD_LAT, upd_vout is ignored, because coeff_update may hold vout high from the previous step.
  - WB:
    - Write a[j] = upd_a_next lane j for j = 1..i.
    - a[0] and a[j>i] are unchanged.
    - If i==ORDER -> DONE; else i++ -> REQ_K.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- upd_aL, upd_aR and upd_k are registered and held constant from ISSUE through WAIT_UPD.
- Lane mapping is computed from i with zero fill above i.
- start while busy is ignored.
- Latency per step: 1 (k handshake, best case) + 1 + UPD_LAT + 1 cycles. Full frame with k_valid already high = ORDER*(UPD_LAT+3)+2.
- coef_out is always a[]; it is valid to consume only at the done pulse.

Optional Feature:
- Macro: LPC_SEQ_WDOG_EN.
- With the macro defined:
  - A counter runs in REQ_K and WAIT_UPD.
  - Reaching WDOG_CYCLES sets err=1 (sticky until rst or next accepted start), pulses done, and returns to IDLE.
  - a[] keeps its last written values.
- Without the macro: no counter; waits are unbounded; err is tied 0.

Decomposition:
- Shared package lpc_pkg holds:
  - constants LPC_ORDER=10, Q15_ONE=16'h7FFF, COEF_W=16, ACC_W=32;
  - the state enum typedef;
  - lane-slice helpers.
- One sub-module is natural: levinson_lane_mux. It is combinational and maps a[] and i to the upd_aL/upd_aR vectors with zero fill.

Test Plan:
- Reset, then start. Bench stubs coeff_update as a_next = aL + ((aR*k)>>>15) with latency 4. k1 = 16'h4000 -> after step 1, a[1] = 16'h3FFF.
- Continuing the same frame: k2 = 16'h2000 -> a[1] = 16'h4FFE, a[2] = 16'h1FFF, a[3..10] = 0.
- All ten k = 0, k_valid held high -> done at cycle 10*7+2 = 72 after start; coef_out = {7FFF, 0...}; upd_v pulsed exactly 10 times.
- Stub holds upd_vout=1 continuously after the first result -> each step still waits 4 cycles; results from the correct step are written, with no early capture.
- Assert rst mid-WAIT_UPD at step 5 -> next cycle busy=0, a[] = {7FFF, 0...}; a subsequent start completes normally. Separately, start pulsed while busy -> ignored, no restart.
- With LPC_SEQ_WDOG_EN, hold k_valid=0 for 64 cycles -> err=1 and a done pulse; the next start clears err.
